handshake_fifo: RTL and testbench

Synchronous ready/valid FIFO that decouples a producer stream from a consumer stream, each following the team's handshake convention (transfer when valid && ready). It sits directly downstream of any block driving a handshake_if and directly upstream of the block consuming it, absorbing backpressure bursts up to DEPTH words. Output is first-word-fall-through with one cycle of write-to-read latency and no combinational path from input to output.

---
 rtl/handshake_fifo_pkg.sv | 8 +
 rtl/handshake_if.sv | 11 +
 rtl/handshake_fifo_mem.sv | 21 ++
 rtl/handshake_fifo.sv | 66 ++++++
 tb/tb_handshake_fifo.sv | 137 +++++++++++++
 5 files changed

// File: rtl/handshake_fifo_pkg.sv
// Shared helpers for the handshake FIFO slice.
package handshake_fifo_pkg;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/handshake_if.sv
// Ready/valid stream bundle; a word moves on any edge where valid && ready.
interface handshake_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/handshake_fifo_mem.sv
// One write port, one asynchronous read port register array.
module handshake_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/handshake_fifo.sv
// First-word-fall-through ready/valid FIFO; all outputs come from registered state.
module handshake_fifo
    import handshake_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = DEPTH - 1,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    handshake_if.slave    s,
    handshake_if.master   m,
    output logic [CW-1:0] count,
    output logic          almost_full
);
    localparam int AW = $clog2(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("handshake_fifo: DEPTH must be a power of two and >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("handshake_fifo: AF_THRESH must be within 1..DEPTH");
    end

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = s.valid && !full;
    assign pop   = m.ready && !empty;

    assign s.ready     = !full;
    assign m.valid     = !empty;
    assign almost_full = (count >= CW'(AF_THRESH));

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    handshake_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr),
        .wdata (s.data),
        .raddr (rd_ptr),
        .rdata (m.data)
    );
endmodule

// File: tb/tb_handshake_fifo.sv
// Randomized and directed checks of handshake_fifo against a queue-based model.
module tb_handshake_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] count;
    logic          almost_full;

    handshake_if #(.DATA_WIDTH(DW)) s_if ();
    handshake_if #(.DATA_WIDTH(DW)) m_if ();

    handshake_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk         (clk),
        .rst         (rst),
        .s           (s_if.slave),
        .m           (m_if.master),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [DW-1:0] q[$];
    bit          model_ok = 0;
    int          n_pushed, n_popped;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Outputs are pure functions of what the FIFO holds.
    task automatic check_outputs();
        if (!model_ok) return;
        chk("m_valid", m_if.valid, q.size() > 0);
        chk("s_ready", s_if.ready, q.size() < DEPTH);
        chk("count", count, q.size());
        chk("almost_full", almost_full, q.size() >= AF);
        if (q.size() > 0) begin
            chk("m_data", m_if.data, q[0]);
            chk("m_data_x", $isunknown(m_if.data), 0);
        end
    endtask

    task automatic cyc(input logic sv, input logic [DW-1:0] sd, input logic mr, input logic r = 1'b0);
        bit pu, po;
        @(negedge clk);
        check_outputs();
        rst = r; s_if.valid = sv; s_if.data = sd; m_if.ready = mr;
        @(posedge clk);
        if (r) begin
            q.delete();
            model_ok = 1;
        end else begin
            pu = sv && (q.size() < DEPTH);
            po = mr && (q.size() > 0);
            if (po) begin void'(q.pop_front()); n_popped++; end
            if (pu) begin q.push_back(sd); n_pushed++; end
        end
        #1;
    endtask

    initial begin
        s_if.valid = 0; s_if.data = '0; m_if.ready = 0;

        // reset with a pending push
        cyc(1, 32'h11, 1, 1);
        cyc(1, 32'h22, 1, 1);
        chk("rst_count", count, 0);
        chk("rst_m_valid", m_if.valid, 0);
        chk("rst_s_ready", s_if.ready, 1);
        chk("rst_af", almost_full, 0);
        cyc(0, 0, 1);
        chk("rst_no_word", m_if.valid, 0);

        // fill then drain
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'hA0 + i, 0);
        chk("fill_s_ready", s_if.ready, 0);
        chk("fill_count", count, 4);
        chk("fill_af", almost_full, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_valid", m_if.valid, 1);
            chk("drain_data", m_if.data, 32'hA0 + i);
            cyc(0, 0, 1);
        end
        chk("drain_empty", m_if.valid, 0);

        // latency: push visible only after the edge
        @(negedge clk);
        chk("lat_pre", m_if.valid, 0);
        cyc(1, 32'h55, 0);
        chk("lat_valid", m_if.valid, 1);
        chk("lat_data", m_if.data, 32'h55);
        cyc(0, 0, 1);

        // full with simultaneous pop: push refused
        for (int i = 0; i < DEPTH; i++) cyc(1, 32'hB0 + i, 0);
        cyc(1, 32'hEE, 1);
        chk("fullpop_count", count, 3);
        chk("fullpop_ready", s_if.ready, 1);
        chk("fullpop_head", m_if.data, 32'hB1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        chk("fullpop_empty", m_if.valid, 0);

        // streaming across pointer wraps
        cyc(1, 0, 1);
        for (int i = 1; i < 20; i++) begin
            chk("stream_count", count, 1);
            chk("stream_data", m_if.data, i - 1);
            cyc(1, i, 1);
        end
        chk("stream_last", m_if.data, 19);
        cyc(0, 0, 1);
        chk("stream_empty", m_if.valid, 0);

        // random stalls
        n_pushed = 0; n_popped = 0;
        for (int c = 0; c < 20000 && n_pushed < 1000; c++)
            cyc(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)));
        for (int c = 0; c < 100 && q.size() > 0; c++) cyc(0, 0, 1'($urandom_range(1)));
        chk("rand_pushed", n_pushed, 1000);
        chk("rand_popped", n_popped, 1000);
        cyc(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
